seq_detect_ctrl: RTL



---
 rtl/seq_detect_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Brief    : Frame sequencer for a serial Moore sequence detector. It clears
//            the detector, shifts a frame into it LSB first and reports a
//            saturating count of det_out-high samples. Optional abort input
//            is enabled by defining SEQ_CTRL_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             det_out,
`ifdef SEQ_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             w,
  output logic             det_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam int               IW          = $clog2(WIDTH);
  localparam logic [IW-1:0]    c_last      = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    c_idx_one   = IW'(1);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [IW-1:0]    r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic             w_abort;
  logic             w_sample;
  logic [CNT_W-1:0] w_cnt_next;

`ifdef SEQ_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // det_out reflects the bit consumed one cycle earlier, so SHIFT k=0 is skipped
  // and DRAIN picks up the result of the final bit.
  assign w_sample   = ((r_state == SHIFT) && (r_idx != '0)) || (r_state == DRAIN);
  assign w_cnt_next = (w_sample && det_out && (r_cnt != c_cnt_max)) ? r_cnt + c_cnt_one : r_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      w           <= 1'b0;
      det_clr     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
    end else begin
      det_clr <= 1'b0;
      done    <= 1'b0;
      if (w_abort && (r_state != IDLE)) begin
        r_state <= IDLE;
        w       <= 1'b0;
        det_clr <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            w <= 1'b0;
            if (start) begin
              r_shreg <= data_in;
              r_cnt   <= '0;
              r_idx   <= '0;
              det_clr <= 1'b1;
              busy    <= 1'b1;
              r_state <= CLEAR;
            end
          end
          CLEAR: begin
            w       <= r_shreg[0];
            r_shreg <= r_shreg >> 1;
            r_idx   <= '0;
            r_state <= SHIFT;
          end
          SHIFT: begin
            r_cnt <= w_cnt_next;
            if (r_idx == c_last) begin
              w       <= 1'b0;
              r_state <= DRAIN;
            end else begin
              w       <= r_shreg[0];
              r_shreg <= r_shreg >> 1;
              r_idx   <= r_idx + c_idx_one;
            end
          end
          DRAIN: begin
            match_count <= w_cnt_next;
            done        <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
